// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Hazard and control unit for a four-stage in-order pipeline.
// It keeps its own copy of stages S2..S4 (valid, opcode, Rx, Ry) and
// advances them every cycle. It stalls fetch on read-after-write hazards
// and flushes the two younger stages on a taken branch in S3. It also
// decodes the stage-3 and stage-4 control signals and counts stall and
// flush cycles in saturating counters.
//
// Ports
//   clk, reset            rising-edge clock, synchronous active-high reset
//   f_op, f_valid         opcode and valid of the instruction in fetch (S1)
//   f_rx, f_ry            register fields of the fetch instruction
//   br_taken              branch condition for the S3 instruction
//   pc_enable, PCSrc      fetch PC update enable and branch-target select
//   flush, stall          pipeline event indications
//   s2/s3/s4_valid, op_*  slot occupancy and opcodes
//   NZ .. br_sel          stage-3 (execute/memory) controls
//   RegWrite .. wr_idx    stage-4 (writeback) controls
//   stall_cnt, flush_cnt  saturating event counters
module pipeline_hazard_ctrl #(
    parameter int REGW   = 3,
    parameter int FWD_EN = 0,
    parameter int CNTW   = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [4:0]      f_op,
    input  logic            f_valid,
    input  logic [REGW-1:0] f_rx,
    input  logic [REGW-1:0] f_ry,
    input  logic            br_taken,
    output logic            pc_enable,
    output logic            PCSrc,
    output logic            flush,
    output logic            stall,
    output logic            s2_valid,
    output logic            s3_valid,
    output logic            s4_valid,
    output logic [4:0]      op_s2,
    output logic [4:0]      op_s3,
    output logic [4:0]      op_s4,
    output logic            NZ,
    output logic            ALUOp,
    output logic            BSrc,
    output logic            ExtSel,
    output logic            BrSrc,
    output logic            MemRead,
    output logic            MemWrite,
    output logic [1:0]      br_sel,
    output logic            RegWrite,
    output logic            RegDst,
    output logic [2:0]      WBSrc,
    output logic [REGW-1:0] wr_idx,
    output logic [CNTW-1:0] stall_cnt,
    output logic [CNTW-1:0] flush_cnt
);

    typedef struct packed {
        logic            valid;
        logic [4:0]      op;
        logic [REGW-1:0] rx;
        logic [REGW-1:0] ry;
    } slot_t;

    slot_t s2_r, s3_r, s4_r;
    slot_t s1, s2, s3, s4;

    logic [REGW-1:0] dest3, dest4;
    logic            haz3, haz4, hazard;

    // A slot writes a register unless it is a branch (op[3]), one of the
    // op[1:0]=11 forms, or a store (00101).
    function automatic logic slot_writes(input slot_t s);
        return s.valid && !s.op[3] && !(s.op[1] && s.op[0]) && (s.op != 5'b00101);
    endfunction

    // Branches record the link register (all ones) as their destination.
    function automatic logic [REGW-1:0] slot_dest(input slot_t s);
        return s.op[3] ? {REGW{1'b1}} : s.rx;
    endfunction

    // While reset is held, everything downstream sees empty slots, so
    // the outputs already look like reset before the first edge clears
    // the registers.
    always_comb begin
        s1 = '0;
        if (f_valid) begin
            s1.valid = 1'b1;
            s1.op    = f_op;
            s1.rx    = f_rx;
            s1.ry    = f_ry;
        end
        s2 = reset ? '0 : s2_r;
        s3 = reset ? '0 : s3_r;
        s4 = reset ? '0 : s4_r;
    end

    // A hazard exists if the S2 instruction reads a register that S3
    // (always) or S4 (only without the writeback bypass) is going to write.
    assign dest3  = slot_dest(s3);
    assign dest4  = slot_dest(s4);
    assign haz3   = slot_writes(s3) && ((dest3 == s2.rx) || (dest3 == s2.ry));
    assign haz4   = (FWD_EN == 0) && slot_writes(s4) && ((dest4 == s2.rx) || (dest4 == s2.ry));
    assign hazard = s2.valid && (haz3 || haz4);

    // A taken branch flushes the wrong-path work, which removes the
    // hazard. For that reason flush wins over stall.
    assign flush     = s3.valid && s3.op[3] && br_taken;
    assign stall     = hazard && !flush;
    assign PCSrc     = flush;
    assign pc_enable = !stall;

    // Slot advance: a flush kills S2/S3, a stall holds S2 and injects a
    // bubble into S3. S4 always takes the old S3.
    always_ff @(posedge clk) begin
        if (reset) begin
            s2_r <= '0;
            s3_r <= '0;
            s4_r <= '0;
        end else if (flush) begin
            s2_r <= '0;
            s3_r <= '0;
            s4_r <= s3_r;
        end else if (stall) begin
            s3_r <= '0;
            s4_r <= s3_r;
        end else begin
            s2_r <= s1;
            s3_r <= s2_r;
            s4_r <= s3_r;
        end
    end

    // Event counters stop at all ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNTW'(1);
            if (flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNTW'(1);
        end
    end

    assign s2_valid = s2.valid;
    assign s3_valid = s3.valid;
    assign s4_valid = s4.valid;
    assign op_s2    = s2.op;
    assign op_s3    = s3.op;
    assign op_s4    = s4.op;

    // Stage-3 and stage-4 decode. Empty slots decode to all zeros.
    always_comb begin
        NZ       = 1'b0;
        ALUOp    = 1'b0;
        BSrc     = 1'b0;
        ExtSel   = 1'b0;
        BrSrc    = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        br_sel   = 2'b00;
        RegWrite = 1'b0;
        RegDst   = 1'b0;
        WBSrc    = 3'b000;
        wr_idx   = '0;
        if (s3.valid) begin
            NZ       = !s3.op[3] && !s3.op[2] && (s3.op[1] || s3.op[0]);
            ALUOp    = !(!s3.op[3] && !s3.op[1] && s3.op[0]);
            BSrc     = s3.op[4];
            ExtSel   = s3.op[3];
            BrSrc    = !s3.op[4];
            MemRead  = (s3.op == 5'b00100);
            MemWrite = (s3.op == 5'b00101);
            br_sel   = s3.op[3] ? s3.op[1:0] : 2'b00;
        end
        if (s4.valid) begin
            RegWrite = slot_writes(s4);
            RegDst   = s4.op[3];
            wr_idx   = dest4;
            case (s4.op)
                5'b00000: WBSrc = 3'b010;
                5'b00100: WBSrc = 3'b000;
                5'b10000: WBSrc = 3'b011;
                5'b10110: WBSrc = 3'b100;
                default:  WBSrc = 3'b001;
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl
// Directed bench for pipeline_hazard_ctrl. Three copies share one
// stimulus stream:
//   dut0  FWD_EN=0, CNTW=16  (main reference)
//   dut1  FWD_EN=1, CNTW=16  (writeback bypass present)
//   dut2  FWD_EN=0, CNTW=2   (small counters, used for saturation)
// Expected values are worked out by hand from the instruction sequence.
module tb_pipeline_hazard_ctrl;

    logic       clk;
    logic       reset;
    logic [4:0] f_op;
    logic       f_valid;
    logic [2:0] f_rx;
    logic [2:0] f_ry;
    logic       br_taken;

    logic       pc_enable_w [3];
    logic       pcsrc_w     [3];
    logic       flush_w     [3];
    logic       stall_w     [3];
    logic       s2v_w       [3];
    logic       s3v_w       [3];
    logic       s4v_w       [3];
    logic [4:0] op_s2_w     [3];
    logic [4:0] op_s3_w     [3];
    logic [4:0] op_s4_w     [3];
    logic       nz_w        [3];
    logic       aluop_w     [3];
    logic       bsrc_w      [3];
    logic       extsel_w    [3];
    logic       brsrc_w     [3];
    logic       memread_w   [3];
    logic       memwrite_w  [3];
    logic [1:0] br_sel_w    [3];
    logic       regwrite_w  [3];
    logic       regdst_w    [3];
    logic [2:0] wbsrc_w     [3];
    logic [2:0] wr_idx_w    [3];
    logic [15:0] stall_cnt0, flush_cnt0, stall_cnt1, flush_cnt1;
    logic [1:0]  stall_cnt2, flush_cnt2;

    int checks   = 0;
    int failures = 0;

    pipeline_hazard_ctrl #(.REGW(3), .FWD_EN(0), .CNTW(16)) dut0 (
        .clk(clk), .reset(reset), .f_op(f_op), .f_valid(f_valid),
        .f_rx(f_rx), .f_ry(f_ry), .br_taken(br_taken),
        .pc_enable(pc_enable_w[0]), .PCSrc(pcsrc_w[0]), .flush(flush_w[0]), .stall(stall_w[0]),
        .s2_valid(s2v_w[0]), .s3_valid(s3v_w[0]), .s4_valid(s4v_w[0]),
        .op_s2(op_s2_w[0]), .op_s3(op_s3_w[0]), .op_s4(op_s4_w[0]),
        .NZ(nz_w[0]), .ALUOp(aluop_w[0]), .BSrc(bsrc_w[0]), .ExtSel(extsel_w[0]),
        .BrSrc(brsrc_w[0]), .MemRead(memread_w[0]), .MemWrite(memwrite_w[0]), .br_sel(br_sel_w[0]),
        .RegWrite(regwrite_w[0]), .RegDst(regdst_w[0]), .WBSrc(wbsrc_w[0]), .wr_idx(wr_idx_w[0]),
        .stall_cnt(stall_cnt0), .flush_cnt(flush_cnt0)
    );

    pipeline_hazard_ctrl #(.REGW(3), .FWD_EN(1), .CNTW(16)) dut1 (
        .clk(clk), .reset(reset), .f_op(f_op), .f_valid(f_valid),
        .f_rx(f_rx), .f_ry(f_ry), .br_taken(br_taken),
        .pc_enable(pc_enable_w[1]), .PCSrc(pcsrc_w[1]), .flush(flush_w[1]), .stall(stall_w[1]),
        .s2_valid(s2v_w[1]), .s3_valid(s3v_w[1]), .s4_valid(s4v_w[1]),
        .op_s2(op_s2_w[1]), .op_s3(op_s3_w[1]), .op_s4(op_s4_w[1]),
        .NZ(nz_w[1]), .ALUOp(aluop_w[1]), .BSrc(bsrc_w[1]), .ExtSel(extsel_w[1]),
        .BrSrc(brsrc_w[1]), .MemRead(memread_w[1]), .MemWrite(memwrite_w[1]), .br_sel(br_sel_w[1]),
        .RegWrite(regwrite_w[1]), .RegDst(regdst_w[1]), .WBSrc(wbsrc_w[1]), .wr_idx(wr_idx_w[1]),
        .stall_cnt(stall_cnt1), .flush_cnt(flush_cnt1)
    );

    pipeline_hazard_ctrl #(.REGW(3), .FWD_EN(0), .CNTW(2)) dut2 (
        .clk(clk), .reset(reset), .f_op(f_op), .f_valid(f_valid),
        .f_rx(f_rx), .f_ry(f_ry), .br_taken(br_taken),
        .pc_enable(pc_enable_w[2]), .PCSrc(pcsrc_w[2]), .flush(flush_w[2]), .stall(stall_w[2]),
        .s2_valid(s2v_w[2]), .s3_valid(s3v_w[2]), .s4_valid(s4v_w[2]),
        .op_s2(op_s2_w[2]), .op_s3(op_s3_w[2]), .op_s4(op_s4_w[2]),
        .NZ(nz_w[2]), .ALUOp(aluop_w[2]), .BSrc(bsrc_w[2]), .ExtSel(extsel_w[2]),
        .BrSrc(brsrc_w[2]), .MemRead(memread_w[2]), .MemWrite(memwrite_w[2]), .br_sel(br_sel_w[2]),
        .RegWrite(regwrite_w[2]), .RegDst(regdst_w[2]), .WBSrc(wbsrc_w[2]), .wr_idx(wr_idx_w[2]),
        .stall_cnt(stall_cnt2), .flush_cnt(flush_cnt2)
    );

    // 10-unit clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one fetch-stage instruction and the branch condition.
    task automatic applyStimulus(input logic v, input logic [4:0] op,
                                 input logic [2:0] rx, input logic [2:0] ry,
                                 input logic br);
        f_valid  = v;
        f_op     = op;
        f_rx     = rx;
        f_ry     = ry;
        br_taken = br;
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One comparison point.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic nops(input int n);
        applyStimulus(1'b0, 5'b00000, 3'd0, 3'd0, 1'b0);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(1'b1, 5'b00001, 3'd1, 3'd2, 1'b0);

        // Reset for two edges with a valid fetch instruction present.
        tick();
        tick();
        checkOutput("rst_s2_valid",  32'(s2v_w[0]),       32'd0);
        checkOutput("rst_s3_valid",  32'(s3v_w[0]),       32'd0);
        checkOutput("rst_s4_valid",  32'(s4v_w[0]),       32'd0);
        checkOutput("rst_stall_cnt", 32'(stall_cnt0),     32'd0);
        checkOutput("rst_flush_cnt", 32'(flush_cnt0),     32'd0);
        checkOutput("rst_pc_enable", 32'(pc_enable_w[0]), 32'd1);
        checkOutput("rst_stall",     32'(stall_w[0]),     32'd0);
        checkOutput("rst_pcsrc",     32'(pcsrc_w[0]),     32'd0);
        checkOutput("rst_regwrite",  32'(regwrite_w[0]),  32'd0);
        reset = 1'b0;

        // Independent ADD stream on distinct registers.
        applyStimulus(1'b1, 5'b00001, 3'd1, 3'd2, 1'b0);
        tick();
        applyStimulus(1'b1, 5'b00001, 3'd3, 3'd4, 1'b0);
        tick();
        applyStimulus(1'b1, 5'b00001, 3'd5, 3'd6, 1'b0);
        tick();
        checkOutput("add_s4_valid", 32'(s4v_w[0]),      32'd1);
        checkOutput("add_op_s4",    32'(op_s4_w[0]),    32'h01);
        checkOutput("add_regwrite", 32'(regwrite_w[0]), 32'd1);
        checkOutput("add_wbsrc",    32'(wbsrc_w[0]),    32'd1);
        checkOutput("add_wr_idx",   32'(wr_idx_w[0]),   32'd1);
        checkOutput("add_regdst",   32'(regdst_w[0]),   32'd0);
        checkOutput("add_nz",       32'(nz_w[0]),       32'd1);
        checkOutput("add_aluop",    32'(aluop_w[0]),    32'd0);
        checkOutput("add_brsrc",    32'(brsrc_w[0]),    32'd1);
        checkOutput("add_stall",    32'(stall_w[0]),    32'd0);
        nops(3);
        checkOutput("add_drained",   32'(s4v_w[0]),   32'd0);
        checkOutput("add_stall_cnt", 32'(stall_cnt0), 32'd0);

        // Load to R2 followed by an ADD reading R2.
        applyStimulus(1'b1, 5'b00100, 3'd2, 3'd0, 1'b0);
        tick();
        applyStimulus(1'b1, 5'b00001, 3'd3, 3'd2, 1'b0);
        tick();
        checkOutput("lu_b2_stall0",   32'(stall_w[0]),     32'd1);
        checkOutput("lu_b2_pcen0",    32'(pc_enable_w[0]), 32'd0);
        checkOutput("lu_b2_stall1",   32'(stall_w[1]),     32'd1);
        checkOutput("lu_b2_memread",  32'(memread_w[0]),   32'd1);
        applyStimulus(1'b0, 5'b00000, 3'd0, 3'd0, 1'b0);
        tick();
        checkOutput("lu_b3_stall0",   32'(stall_w[0]),    32'd1);
        checkOutput("lu_b3_stall1",   32'(stall_w[1]),    32'd0);
        checkOutput("lu_b3_cnt0",     32'(stall_cnt0),    32'd1);
        checkOutput("lu_b3_wbsrc",    32'(wbsrc_w[0]),    32'd0);
        checkOutput("lu_b3_wr_idx",   32'(wr_idx_w[0]),   32'd2);
        checkOutput("lu_b3_regwrite", 32'(regwrite_w[0]), 32'd1);
        checkOutput("lu_b3_s3_valid", 32'(s3v_w[0]),      32'd0);
        tick();
        checkOutput("lu_b4_stall0",   32'(stall_w[0]),  32'd0);
        checkOutput("lu_b4_cnt0",     32'(stall_cnt0),  32'd2);
        checkOutput("lu_b4_cnt1",     32'(stall_cnt1),  32'd1);
        checkOutput("lu_b4_cnt2",     32'(stall_cnt2),  32'd2);
        checkOutput("lu_b4_op_s2_0",  32'(op_s2_w[0]),  32'h01);
        checkOutput("lu_b4_s3v1",     32'(s3v_w[1]),    32'd1);
        checkOutput("lu_b4_op_s3_1",  32'(op_s3_w[1]),  32'h01);
        nops(4);

        // Branch 01001 in S3: first not taken, then taken.
        applyStimulus(1'b1, 5'b01001, 3'd1, 3'd2, 1'b0);
        tick();
        applyStimulus(1'b1, 5'b00001, 3'd4, 3'd5, 1'b0);
        tick();
        checkOutput("br_nt_flush",  32'(flush_w[0]),  32'd0);
        checkOutput("br_nt_pcsrc",  32'(pcsrc_w[0]),  32'd0);
        checkOutput("br_br_sel",    32'(br_sel_w[0]), 32'd1);
        checkOutput("br_extsel",    32'(extsel_w[0]), 32'd1);
        applyStimulus(1'b1, 5'b00001, 3'd6, 3'd6, 1'b1);
        #1;
        checkOutput("br_t_flush",  32'(flush_w[0]),     32'd1);
        checkOutput("br_t_pcsrc",  32'(pcsrc_w[0]),     32'd1);
        checkOutput("br_t_pcen",   32'(pc_enable_w[0]), 32'd1);
        tick();
        checkOutput("br_s2_valid",  32'(s2v_w[0]),      32'd0);
        checkOutput("br_s3_valid",  32'(s3v_w[0]),      32'd0);
        checkOutput("br_flush_cnt", 32'(flush_cnt0),    32'd1);
        checkOutput("br_flush_off", 32'(flush_w[0]),    32'd0);
        checkOutput("br_op_s4",     32'(op_s4_w[0]),    32'h09);
        checkOutput("br_regdst",    32'(regdst_w[0]),   32'd1);
        checkOutput("br_wr_idx",    32'(wr_idx_w[0]),   32'd7);
        checkOutput("br_regwrite",  32'(regwrite_w[0]), 32'd0);
        nops(3);

        // Hazard against S4 and a taken branch in S3 at the same time.
        applyStimulus(1'b1, 5'b00100, 3'd2, 3'd0, 1'b0);
        tick();
        applyStimulus(1'b1, 5'b01001, 3'd0, 3'd1, 1'b0);
        tick();
        applyStimulus(1'b1, 5'b00001, 3'd3, 3'd2, 1'b0);
        tick();
        checkOutput("hf_stall_pre", 32'(stall_w[0]), 32'd1);
        applyStimulus(1'b0, 5'b00000, 3'd0, 3'd0, 1'b1);
        #1;
        checkOutput("hf_flush", 32'(flush_w[0]),     32'd1);
        checkOutput("hf_stall", 32'(stall_w[0]),     32'd0);
        checkOutput("hf_pcen",  32'(pc_enable_w[0]), 32'd1);
        tick();
        checkOutput("hf_stall_cnt", 32'(stall_cnt0), 32'd2);
        checkOutput("hf_flush_cnt", 32'(flush_cnt0), 32'd2);
        checkOutput("hf_s2_valid",  32'(s2v_w[0]),   32'd0);
        nops(3);

        // Two more load-use pairs push the 2-bit counter past its top.
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1'b1, 5'b00100, 3'd2, 3'd0, 1'b0);
            tick();
            applyStimulus(1'b1, 5'b00001, 3'd3, 3'd2, 1'b0);
            tick();
            nops(5);
        end
        checkOutput("sat_cnt0", 32'(stall_cnt0), 32'd6);
        checkOutput("sat_cnt1", 32'(stall_cnt1), 32'd3);
        checkOutput("sat_cnt2", 32'(stall_cnt2), 32'd3);

        // Reset in the middle of a stall.
        applyStimulus(1'b1, 5'b00100, 3'd2, 3'd0, 1'b0);
        tick();
        applyStimulus(1'b1, 5'b00001, 3'd3, 3'd2, 1'b0);
        tick();
        checkOutput("mr_stall_pre", 32'(stall_w[0]), 32'd1);
        reset = 1'b1;
        #1;
        checkOutput("mr_stall_held", 32'(stall_w[0]),     32'd0);
        checkOutput("mr_pcen_held",  32'(pc_enable_w[0]), 32'd1);
        tick();
        checkOutput("mr_s2_valid",  32'(s2v_w[0]),   32'd0);
        checkOutput("mr_s3_valid",  32'(s3v_w[0]),   32'd0);
        checkOutput("mr_s4_valid",  32'(s4v_w[0]),   32'd0);
        checkOutput("mr_stall_cnt", 32'(stall_cnt0), 32'd0);
        checkOutput("mr_flush_cnt", 32'(flush_cnt0), 32'd0);
        reset = 1'b0;
        nops(1);
        checkOutput("mr_after_cnt",  32'(stall_cnt0),     32'd0);
        checkOutput("mr_after_s2",   32'(s2v_w[0]),       32'd0);
        checkOutput("mr_after_pcen", 32'(pc_enable_w[0]), 32'd1);

        // Writeback source and store decode.
        applyStimulus(1'b1, 5'b10000, 3'd1, 3'd1, 1'b0);
        tick();
        applyStimulus(1'b1, 5'b10110, 3'd4, 3'd4, 1'b0);
        tick();
        checkOutput("wb_nz",    32'(nz_w[0]),    32'd0);
        checkOutput("wb_aluop", 32'(aluop_w[0]), 32'd1);
        checkOutput("wb_bsrc",  32'(bsrc_w[0]),  32'd1);
        checkOutput("wb_brsrc", 32'(brsrc_w[0]), 32'd0);
        applyStimulus(1'b1, 5'b00101, 3'd5, 3'd5, 1'b0);
        tick();
        checkOutput("wb_10000_src", 32'(wbsrc_w[0]),    32'd3);
        checkOutput("wb_10000_rw",  32'(regwrite_w[0]), 32'd1);
        applyStimulus(1'b0, 5'b00000, 3'd0, 3'd0, 1'b0);
        tick();
        checkOutput("wb_10110_src", 32'(wbsrc_w[0]),    32'd4);
        checkOutput("st_memwrite",  32'(memwrite_w[0]), 32'd1);
        checkOutput("st_aluop",     32'(aluop_w[0]),    32'd0);
        tick();
        checkOutput("st_regwrite",  32'(regwrite_w[0]), 32'd0);
        checkOutput("st_wbsrc",     32'(wbsrc_w[0]),    32'd1);
        checkOutput("st_wr_idx",    32'(wr_idx_w[0]),   32'd5);
        checkOutput("wb_stall_cnt", 32'(stall_cnt0),    32'd0);
        nops(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
